hps_state_sequencer: RTL and testbench
======================================

HPS_STATE_SEQUENCER -- requirements
Module: hps_state_sequencer

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4: consecutive identical synchronized samples of state_in required before a command is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000000: watchdog limit in clk cycles.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port state_in, input, 10: HPS command word from the HPS state output PIO; [1:0] command, [9:2] frame count.
REQ-006 Port sof, input, 1: camera start-of-frame, single-cycle pulse.
REQ-007 Port eof, input, 1: camera end-of-frame, single-cycle pulse.
REQ-008 Port proc_done, input, 1: clean pipeline completion, single-cycle pulse.
REQ-009 Port start_cap, output, 1: one-cycle capture-start pulse to the camera write path.
REQ-010 Port proc_en, output, 1: clean pipeline enable.
REQ-011 Port busy, output, 1: high in every state except IDLE and DONE.
REQ-012 Port status, output, 8: to the HPS status input PIO; [2:0] state, [3] busy, [4] done, [5] cmd_rejected, [6] timeout, [7] 0.

Function
REQ-013 SHALL pass state_in through a 2-flop synchronizer.
REQ-014 SHALL accept a command when the synchronized value has been equal for STABLE_CYC consecutive cycles and differs from the last accepted value; acceptance generates a one-cycle internal strobe.
REQ-015 Command codes: 00 ABORT, 01 SINGLE (count frames), 10 CONTINUOUS, 11 CLEAN.
REQ-016 States: IDLE=0, WAIT_SOF=1, CAPTURE=2, PROCESS=3, DONE=4.
REQ-017 ABORT strobe in any state SHALL go to IDLE on the next cycle, deassert proc_en, and clear status[6:4].
REQ-018 IDLE or DONE plus a non-ABORT strobe SHALL go to WAIT_SOF, clear done and timeout, and latch frames_left = state_in[9:2]; value 0 means 256.
REQ-019 WAIT_SOF plus sof SHALL go to CAPTURE; start_cap is registered and high for exactly the first CAPTURE cycle.
REQ-020 CAPTURE plus eof, by command:
- SINGLE: frames_left==1 goes to DONE; otherwise decrement frames_left and go to WAIT_SOF.
- CONTINUOUS: go to WAIT_SOF, no count.
- CLEAN: go to PROCESS.
REQ-021 PROCESS SHALL hold proc_en=1; proc_done goes to DONE, and proc_en is 0 in DONE.
REQ-022 DONE SHALL hold status[4]=1 until the next accepted strobe.
REQ-023 A non-ABORT strobe while busy SHALL be ignored and SHALL set sticky status[5], cleared only by ABORT or reset.
REQ-024 sof and eof in the same cycle: in WAIT_SOF only sof acts; in CAPTURE only eof acts.
REQ-025 sof, eof and proc_done outside their consuming states SHALL be ignored.
REQ-026 A strobe and sof/eof in the same cycle: the strobe takes priority.

Reset
REQ-027 Reset SHALL set state IDLE, start_cap=0, proc_en=0, busy=0, status=8'h00, frames_left=0, synchronizer and stability counter 0, and last accepted command 0 (ABORT).
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no pulse emitted after reset release.

Configuration
REQ-029 Macro HPS_STATE_TIMEOUT_EN defined: a watchdog counts cycles spent in WAIT_SOF, CAPTURE and PROCESS, clears on every state transition, and on reaching TIMEOUT_CYC forces DONE with status[6]=1 and proc_en=0.
REQ-030 Macro absent: no watchdog logic, and status[6] is tied to 0.

Structure
REQ-031 Package hps_state_pkg SHALL hold the state enum, the command code constants and the status bit index constants.
REQ-032 Sub-module hps_state_sync SHALL contain the synchronizer and stability filter and output the accepted command word and the strobe.

Verification
REQ-033 Reset, then state_in=10'h009 (SINGLE, 2 frames), stable, then sof, eof, sof, eof:
- exactly two start_cap pulses;
- status=8'h04 | 8'h10 = 8'h14 after the second eof.
REQ-034 state_in=10'h003 (CLEAN), then sof, then eof:
- proc_en rises one cycle after eof;
- proc_done then gives proc_en=0 and status[4]=1.
REQ-035 state_in glitches to 10'h002 for 2 cycles with STABLE_CYC=4: no strobe, and state remains IDLE.
REQ-036 Start CONTINUOUS (10'h002), then write 10'h001 while in CAPTURE: command ignored and status[5]=1; then write 10'h000: IDLE and status=8'h00.
REQ-037 sof and eof asserted together in CAPTURE with SINGLE and frames_left=1: DONE, and no new start_cap.
REQ-038 With HPS_STATE_TIMEOUT_EN and TIMEOUT_CYC=100, start SINGLE and give no sof: DONE at cycle 100 with status[6]=1.

Source files
------------

// File: rtl/hps_state_pkg.sv
// Shared types and constants for the HPS capture/process sequencer.
// Watchdog build option: HPS_STATE_TIMEOUT_EN (see hps_state_sequencer).
package hps_state_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_PROCESS  = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam int CMD_W = 10;

  localparam logic [1:0] CMD_ABORT      = 2'b00;
  localparam logic [1:0] CMD_SINGLE     = 2'b01;
  localparam logic [1:0] CMD_CONTINUOUS = 2'b10;
  localparam logic [1:0] CMD_CLEAN      = 2'b11;

  localparam int STAT_BUSY    = 3;
  localparam int STAT_DONE    = 4;
  localparam int STAT_REJECT  = 5;
  localparam int STAT_TIMEOUT = 6;

endpackage

// File: rtl/hps_state_sync.sv
// Synchronizes the HPS command word and accepts it once it has been stable
// for STABLE_CYC samples and differs from the previously accepted word.
module hps_state_sync
  import hps_state_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CMD_W-1:0] state_in,
  output logic [CMD_W-1:0] cmd_word,
  output logic             cmd_strobe
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

  logic [CMD_W-1:0] sync_q1;
  logic [CMD_W-1:0] sync_q2;
  logic [CMD_W-1:0] cand;
  logic [CNT_W-1:0] stable_cnt;
  logic             accept;

  // cand holds the value being qualified; stable_cnt counts its consecutive samples
  assign accept = (stable_cnt == CNT_MAX) && (cand != cmd_word);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1    <= '0;
      sync_q2    <= '0;
      cand       <= '0;
      stable_cnt <= '0;
      cmd_word   <= '0;
      cmd_strobe <= 1'b0;
    end else begin
      sync_q1 <= state_in;
      sync_q2 <= sync_q1;
      if (sync_q2 != cand) begin
        cand       <= sync_q2;
        stable_cnt <= CNT_W'(1);
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      cmd_strobe <= accept;
      if (accept) cmd_word <= cand;
    end
  end

endmodule

// File: rtl/hps_state_sequencer.sv
// Frame capture / clean-pipeline sequencer driven by the HPS command PIO.
// Define HPS_STATE_TIMEOUT_EN to add a per-state watchdog of TIMEOUT_CYC cycles.
//
//   state    | meaning
//   IDLE     | no operation, waiting for a command
//   WAIT_SOF | armed, waiting for camera start-of-frame
//   CAPTURE  | frame being written, waiting for end-of-frame
//   PROCESS  | clean pipeline enabled, waiting for proc_done
//   DONE     | operation finished (or timed out), status[4] held
module hps_state_sequencer
  import hps_state_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CMD_W-1:0] state_in,
  input  logic             sof,
  input  logic             eof,
  input  logic             proc_done,
  output logic             start_cap,
  output logic             proc_en,
  output logic             busy,
  output logic [7:0]       status
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t           state, next_state;
  logic [CMD_W-1:0] cmd_word;
  logic             cmd_strobe;
  logic [1:0]       mode;
  logic [8:0]       frames_left;
  logic             rejected, timed_out, timeout_hit;
  logic             abort_req, start_req, reject_req;

  hps_state_sync #(.STABLE_CYC(STABLE_CYC)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .state_in   (state_in),
    .cmd_word   (cmd_word),
    .cmd_strobe (cmd_strobe)
  );

  assign abort_req  = cmd_strobe && (cmd_word[1:0] == CMD_ABORT);
  assign start_req  = cmd_strobe && !abort_req && !busy;
  assign reject_req = cmd_strobe && !abort_req && busy;

`ifdef HPS_STATE_TIMEOUT_EN
  localparam logic [31:0] WD_LOAD = 32'(TIMEOUT_CYC - 1);
  logic [31:0] wd_cnt;

  // down-counter reloaded on every transition; terminal count forces DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             wd_cnt <= WD_LOAD;
    else if (!busy || (next_state != state)) wd_cnt <= WD_LOAD;
    else if (wd_cnt != 32'd0)                wd_cnt <= wd_cnt - 32'd1;
  end

  assign timeout_hit = busy && (wd_cnt == 32'd0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort_req)        next_state = ST_IDLE;
    else if (start_req)   next_state = ST_WAIT_SOF;
    else if (timeout_hit) next_state = ST_DONE;
    else begin
      case (state)
        ST_WAIT_SOF: if (sof) next_state = ST_CAPTURE;
        ST_CAPTURE: begin
          if (eof) begin
            case (mode)
              CMD_SINGLE: next_state = (frames_left == 9'd1) ? ST_DONE : ST_WAIT_SOF;
              CMD_CLEAN:  next_state = ST_PROCESS;
              default:    next_state = ST_WAIT_SOF;
            endcase
          end
        end
        ST_PROCESS:  if (proc_done) next_state = ST_DONE;
        default:     next_state = state;
      endcase
    end
  end

  always_comb begin
    busy    = (state != ST_IDLE) && (state != ST_DONE);
    proc_en = (state == ST_PROCESS);
    status  = 8'h00;
    status[2:0]          = state;
    status[STAT_BUSY]    = busy;
    status[STAT_DONE]    = (state == ST_DONE);
    status[STAT_REJECT]  = rejected;
    status[STAT_TIMEOUT] = timed_out;
  end

  // frame count 0 encodes 256, hence the 9-bit counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_cap   <= 1'b0;
      mode        <= CMD_ABORT;
      frames_left <= 9'd0;
      rejected    <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      start_cap <= (state == ST_WAIT_SOF) && (next_state == ST_CAPTURE);
      if (abort_req) begin
        rejected  <= 1'b0;
        timed_out <= 1'b0;
      end else if (start_req) begin
        timed_out   <= 1'b0;
        mode        <= cmd_word[1:0];
        frames_left <= {(cmd_word[9:2] == 8'd0), cmd_word[9:2]};
      end else begin
        if (reject_req)  rejected  <= 1'b1;
        if (timeout_hit) timed_out <= 1'b1;
        if ((state == ST_CAPTURE) && eof && (mode == CMD_SINGLE) &&
            (next_state == ST_WAIT_SOF))
          frames_left <= frames_left - 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_hps_state_sequencer.sv
// Directed bench for hps_state_sequencer; timeout checks follow HPS_STATE_TIMEOUT_EN.
module tb_hps_state_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] state_in;
  logic       sof, eof, proc_done;
  logic       start_cap, proc_en, busy;
  logic [7:0] status;

  int n_checks = 0;
  int n_errors = 0;
  int cap_cnt  = 0;

  hps_state_sequencer #(.STABLE_CYC(4), .TIMEOUT_CYC(100)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .state_in  (state_in),
    .sof       (sof),
    .eof       (eof),
    .proc_done (proc_done),
    .start_cap (start_cap),
    .proc_en   (proc_en),
    .busy      (busy),
    .status    (status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start_cap === 1'b1) cap_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic e, input logic d);
    sof = s; eof = e; proc_done = d;
    @(negedge clk);
    sof = 1'b0; eof = 1'b0; proc_done = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] tgt, input int budget);
    int n = 0;
    while (status[2:0] !== tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, status[2:0], tgt);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c0, n, bad;
    reset_n = 1'b0; state_in = 10'h000; sof = 1'b0; eof = 1'b0; proc_done = 1'b0;
    cyc(3);
    chk("rst_status", status, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_proc_en", proc_en, 0);
    chk("rst_start_cap", start_cap, 0);
    reset_n = 1'b1;
    cyc(10);
    chk("idle_after_rst", status, 8'h00);

    // SINGLE, 2 frames
    c0 = cap_cnt;
    state_in = 10'h009;
    wait_state("t1_wait_sof", 3'd1, 30);
    chk("t1_status_wait", status, 8'h09);
    pulse(1, 0, 0);
    chk("t1_start_cap_hi", start_cap, 1);
    chk("t1_status_cap", status, 8'h0A);
    cyc(1);
    chk("t1_start_cap_lo", start_cap, 0);
    pulse(0, 1, 0);
    chk("t1_frame1_done", status, 8'h09);
    pulse(1, 0, 0);
    cyc(2);
    pulse(0, 1, 0);
    chk("t1_done_status", status, 8'h14);
    chk("t1_cap_pulses", cap_cnt - c0, 2);

    // CLEAN
    state_in = 10'h003;
    wait_state("t2_wait_sof", 3'd1, 30);
    pulse(1, 0, 0);
    cyc(1);
    chk("t2_proc_en_pre", proc_en, 0);
    pulse(0, 1, 0);
    chk("t2_proc_en_rise", proc_en, 1);
    chk("t2_status_proc", status, 8'h0B);
    cyc(3);
    chk("t2_proc_en_hold", proc_en, 1);
    pulse(0, 0, 1);
    chk("t2_proc_en_fall", proc_en, 0);
    chk("t2_done_status", status, 8'h14);
    c0 = cap_cnt;
    pulse(1, 1, 1);
    cyc(1);
    chk("t2_done_ignores", status, 8'h14);
    chk("t2_no_cap_in_done", cap_cnt - c0, 0);

    // ABORT then a short glitch
    state_in = 10'h000;
    wait_state("t3_abort", 3'd0, 30);
    chk("t3_idle_status", status, 8'h00);
    pulse(1, 0, 0);
    chk("t3_idle_ignores_sof", status, 8'h00);
    state_in = 10'h002;
    cyc(3);
    state_in = 10'h000;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (status !== 8'h00) bad = 1;
    end
    chk("t3_glitch_ignored", bad, 0);

    // CONTINUOUS with a rejected command while busy
    state_in = 10'h002;
    wait_state("t4_wait_sof", 3'd1, 30);
    pulse(1, 0, 0);
    chk("t4_capture", status, 8'h0A);
    state_in = 10'h001;
    cyc(12);
    chk("t4_rejected", status, 8'h2A);
    pulse(0, 1, 0);
    chk("t4_cont_rearm", status, 8'h29);
    pulse(1, 0, 0);
    chk("t4_cont_capture", status, 8'h2A);
    state_in = 10'h000;
    wait_state("t4_abort", 3'd0, 30);
    chk("t4_abort_status", status, 8'h00);

    // sof+eof together in WAIT_SOF then in CAPTURE, last frame
    state_in = 10'h005;
    wait_state("t5_wait_sof", 3'd1, 30);
    c0 = cap_cnt;
    pulse(1, 1, 0);
    chk("t5_sof_wins", status, 8'h0A);
    pulse(1, 1, 0);
    chk("t5_eof_wins", status, 8'h14);
    cyc(2);
    chk("t5_single_cap", cap_cnt - c0, 1);

    // frame count 0 means 256
    state_in = 10'h000;
    wait_state("t6_abort", 3'd0, 30);
    state_in = 10'h001;
    wait_state("t6_wait_sof", 3'd1, 30);
    for (int i = 0; i < 255; i++) begin
      pulse(1, 0, 0);
      pulse(0, 1, 0);
    end
    chk("t6_after_255", status, 8'h09);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    chk("t6_after_256", status, 8'h14);

    // watchdog
    state_in = 10'h000;
    wait_state("t7_abort", 3'd0, 30);
    state_in = 10'h009;
    wait_state("t7_wait_sof", 3'd1, 30);
`ifdef HPS_STATE_TIMEOUT_EN
    n = 0;
    while (status[2:0] === 3'd1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("t7_timeout_cycles", n, 100);
    chk("t7_timeout_status", status, 8'h54);
`else
    n = 0;
    cyc(150);
    chk("t7_no_watchdog", status, 8'h09);
`endif
    state_in = 10'h000;
    wait_state("t7_abort2", 3'd0, 30);
    chk("t7_abort_clears", status, 8'h00);

    // reset mid-capture
    state_in = 10'h002;
    wait_state("t8_wait_sof", 3'd1, 30);
    pulse(1, 0, 0);
    chk("t8_capture", status, 8'h0A);
    reset_n = 1'b0;
    state_in = 10'h000;
    cyc(2);
    chk("t8_in_reset", status, 8'h00);
    reset_n = 1'b1;
    c0 = cap_cnt;
    cyc(12);
    chk("t8_after_reset", status, 8'h00);
    chk("t8_no_cap", cap_cnt - c0, 0);
    chk("t8_proc_en", proc_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
